intp_ctrl: RTL and testbench

//  Fixed-priority interrupt controller between the SoC interrupt sources and the Yduck core.

---
 rtl/intp_ctrl.sv | 146 ++++++++++++++
 tb/tb_intp_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/intp_ctrl.sv
// Fixed-priority interrupt controller: edge capture, pending/enable
// registers and a req/ack/eoi handshake towards the core.
module intp_ctrl #(
  parameter int DW          = 16,
  parameter int NEXT        = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          intp_s,
  input  logic [3:0]    intp_ext,
  input  logic [1:0]    tmr_irq,
  input  logic          reg_we,
  input  logic [1:0]    reg_addr,
  input  logic [DW-1:0] reg_wdata,
  output logic [DW-1:0] reg_rdata,
  output logic          irq_req,
  output logic [2:0]    irq_id,
  input  logic          irq_ack,
  input  logic          irq_eoi
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERV
  } state_t;

  state_t state_q, state_d;

  logic [NEXT-1:0] sync_q [SYNC_STAGES];
  logic [NEXT-1:0] ext_prev_q;
  logic [1:0]      tmr_prev_q;
  logic            s_prev_q;

  logic [6:0] pend_q, pend_d;
  logic [6:0] en_q, en_d;
  logic [2:0] id_q, id_d;
  logic       req_q, req_d;

  logic [6:0] hw_set;
  logic [6:0] w1c;
  logic [6:0] sws;
  logic [6:0] ack_clr;
  logic [6:0] active;
  logic [2:0] win;

  assign hw_set = {tmr_irq & ~tmr_prev_q,
                   sync_q[SYNC_STAGES-1] & ~ext_prev_q,
                   intp_s & ~s_prev_q};

  assign active = pend_q & en_q;

  always_comb begin
    win = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (active[i]) win = 3'(i);
    end
  end

  always_comb begin
    w1c  = '0;
    sws  = '0;
    en_d = en_q;
    if (reg_we) begin
      unique case (1'b1)
        reg_addr == 2'd0: en_d = reg_wdata[6:0] | 7'h01;
        reg_addr == 2'd1: w1c  = reg_wdata[6:0];
        reg_addr == 2'd3: sws  = reg_wdata[6:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    req_d   = req_q;
    ack_clr = '0;
    unique case (state_q)
      IDLE: begin
        if (|active) begin
          state_d = REQ;
          id_d    = win;
          req_d   = 1'b1;
        end
      end
      REQ: begin
        // ack wins over a same-cycle eoi
        if (irq_ack) begin
          state_d = SERV;
          req_d   = 1'b0;
          ack_clr = 7'd1 << id_q;
        end
      end
      SERV: begin
        if (irq_eoi) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
    // hardware/software set applied last so it beats clears
    pend_d = (pend_q & ~w1c & ~ack_clr) | sws | hw_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      ext_prev_q <= '0;
      tmr_prev_q <= '0;
      s_prev_q   <= 1'b0;
      pend_q     <= '0;
      en_q       <= 7'h01;
      id_q       <= 3'd0;
      req_q      <= 1'b0;
      state_q    <= IDLE;
    end else begin
      sync_q[0] <= intp_ext;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      ext_prev_q <= sync_q[SYNC_STAGES-1];
      tmr_prev_q <= tmr_irq;
      s_prev_q   <= intp_s;
      pend_q     <= pend_d;
      en_q       <= en_d;
      id_q       <= id_d;
      req_q      <= req_d;
      state_q    <= state_d;
    end
  end

  always_comb begin
    reg_rdata = '0;
    unique case (reg_addr)
      2'd0: reg_rdata[6:0] = en_q;
      2'd1: reg_rdata[6:0] = pend_q;
      2'd2: reg_rdata[3:0] = {state_q == SERV, id_q};
      default: reg_rdata = '0;
    endcase
  end

  assign irq_req = req_q;
  assign irq_id  = id_q;

endmodule

// File: tb/tb_intp_ctrl.sv
// Scoreboard bench for intp_ctrl: expected ids queued at stimulus,
// popped when the controller raises irq_req.
module tb_intp_ctrl;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          intp_s;
  logic [3:0]    intp_ext;
  logic [1:0]    tmr_irq;
  logic          reg_we;
  logic [1:0]    reg_addr;
  logic [DW-1:0] reg_wdata;
  logic [DW-1:0] reg_rdata;
  logic          irq_req;
  logic [2:0]    irq_id;
  logic          irq_ack;
  logic          irq_eoi;

  int n_chk = 0;
  int n_err = 0;
  int exp_q[$];
  int v;

  intp_ctrl #(.DW(DW), .NEXT(4), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .intp_s    (intp_s),
    .intp_ext  (intp_ext),
    .tmr_irq   (tmr_irq),
    .reg_we    (reg_we),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .irq_req   (irq_req),
    .irq_id    (irq_id),
    .irq_ack   (irq_ack),
    .irq_eoi   (irq_eoi)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input logic [1:0] a, output int d);
    reg_addr = a;
    #1;
    d = int'(reg_rdata);
  endtask

  task automatic wr(input logic [1:0] a, input int d);
    reg_we    = 1'b1;
    reg_addr  = a;
    reg_wdata = DW'(d);
    @(negedge clk);
    reg_we    = 1'b0;
  endtask

  task automatic wait_req();
    int k = 0;
    while (!irq_req && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("req_seen", int'(irq_req), 1);
    if (exp_q.size() > 0) chk("irq_id", int'(irq_id), exp_q.pop_front());
    else chk("sb_underflow", 1, 0);
  endtask

  task automatic ack_eoi();
    int id;
    int d;
    id = int'(irq_id);
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
    chk("req_drop", int'(irq_req), 0);
    rd(2'd2, d);
    chk("stat_serv", d, 8 | id);
    irq_eoi = 1'b1;
    @(negedge clk);
    irq_eoi = 1'b0;
    rd(2'd2, d);
    chk("stat_idle", d & 8, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    intp_s    = 1'b0;
    intp_ext  = '0;
    tmr_irq   = '0;
    reg_we    = 1'b0;
    reg_addr  = '0;
    reg_wdata = '0;
    irq_ack   = 1'b0;
    irq_eoi   = 1'b0;
    tick(3);
    chk("rst_req", int'(irq_req), 0);
    chk("rst_id", int'(irq_id), 0);
    rd(2'd0, v); chk("rst_en", v, 1);
    rd(2'd1, v); chk("rst_pend", v, 0);
    rst_n = 1'b1;
    tick(2);
    rd(2'd3, v); chk("swset_rd", v, 0);
    wr(2'd0, 0); rd(2'd0, v); chk("en0_fixed", v, 1);

    // forced interrupt latency and level-held-once
    intp_s = 1'b1;
    exp_q.push_back(0);
    tick(1);
    chk("s_lat1", int'(irq_req), 0);
    rd(2'd1, v); chk("s_pend", v, 1);
    tick(1);
    chk("s_lat2", int'(irq_req), 1);
    wait_req();
    ack_eoi();
    rd(2'd1, v); chk("s_pend_clr", v, 0);
    tick(3);
    chk("level_once", int'(irq_req), 0);
    intp_s = 1'b0;

    // ext2 and tmr1 land in PEND together: ext2 wins
    wr(2'd0, 'h7f);
    intp_ext[2] = 1'b1;
    tick(2);
    tmr_irq[1] = 1'b1;
    exp_q.push_back(3);
    exp_q.push_back(6);
    tick(1);
    rd(2'd1, v); chk("pend_pair", v, 'h48);
    wait_req();
    ack_eoi();
    wait_req();
    ack_eoi();
    intp_ext = '0;
    tmr_irq  = '0;
    tick(3);

    // masked pending released by enable write
    wr(2'd0, 'h01);
    intp_ext[0] = 1'b1;
    tick(5);
    rd(2'd1, v); chk("masked_pend", v, 'h02);
    chk("masked_noreq", int'(irq_req), 0);
    exp_q.push_back(1);
    wr(2'd0, 'h03);
    wait_req();
    ack_eoi();
    intp_ext = '0;

    // no re-arbitration while in REQ
    wr(2'd0, 'h7f);
    tmr_irq[0] = 1'b1;
    exp_q.push_back(5);
    wait_req();
    intp_s = 1'b1;
    tick(3);
    chk("hold_id", int'(irq_id), 5);
    chk("hold_req", int'(irq_req), 1);
    rd(2'd1, v); chk("hold_pend", v, 'h21);
    exp_q.push_back(0);
    ack_eoi();
    wait_req();
    ack_eoi();
    intp_s  = 1'b0;
    tmr_irq = '0;
    tick(2);

    // hardware set beats same-cycle W1C
    wr(2'd0, 'h01);
    wr(2'd3, 'h20);
    rd(2'd1, v); chk("swset", v, 'h20);
    reg_we     = 1'b1;
    reg_addr   = 2'd1;
    reg_wdata  = DW'('h20);
    tmr_irq[0] = 1'b1;
    @(negedge clk);
    reg_we = 1'b0;
    rd(2'd1, v); chk("set_wins", v, 'h20);
    wr(2'd1, 'h20);
    rd(2'd1, v); chk("w1c", v, 0);
    tmr_irq = '0;

    // async reset during service
    intp_s = 1'b1;
    exp_q.push_back(0);
    wait_req();
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
    intp_s  = 1'b0;
    wr(2'd3, 'h40);
    rd(2'd2, v); chk("pre_rst_stat", v, 8);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", int'(irq_req), 0);
    rd(2'd2, v); chk("mid_rst_stat", v, 0);
    rd(2'd1, v); chk("mid_rst_pend", v, 0);
    rd(2'd0, v); chk("mid_rst_en", v, 1);
    tick(1);
    rst_n = 1'b1;
    tick(3);
    chk("post_rst_req", int'(irq_req), 0);
    chk("sb_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
